// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared state encoding and default address map for the pattern-count sequencer
package pattern_scan_pkg;
  typedef enum logic [2:0] {IDLE, LDPAT, SCAN, WR0, WR1, WR2, DONE} state_e;
  localparam int         MSG_BYTES_DEF = 32;
  localparam logic [7:0] MSG_BASE_DEF  = 8'd0;
  localparam logic [7:0] PAT_ADDR_DEF  = 8'd32;
  localparam logic [7:0] RES_ADDR_DEF  = 8'd33;
  localparam logic [7:0] OFF_CTB       = 8'd0;
  localparam logic [7:0] OFF_CTO       = 8'd1;
  localparam logic [7:0] OFF_CTS       = 8'd2;
endpackage

// File: rtl/pattern_window_match.sv
// pattern_window_match: counts 5-bit pattern hits inside one byte and across the boundary with the previous byte
//   pat     pattern to match
//   cur     current message byte
//   prev    previous message byte (low nibble forms the crossing windows)
//   first   high for byte 0, which has no crossing windows
//   in_cnt  in-byte hits (0..4), any_hit = in_cnt != 0, x_cnt = crossing hits (0..4)
module pattern_window_match (
  input  logic [4:0] pat,
  input  logic [7:0] cur,
  input  logic [7:0] prev,
  input  logic       first,
  output logic [2:0] in_cnt,
  output logic       any_hit,
  output logic [2:0] x_cnt
);
  logic [11:0] w;
  assign w = {prev[3:0], cur};
  always_comb begin
    in_cnt = '0;
    x_cnt  = '0;
    for (int k = 0; k < 4; k++) begin
      in_cnt = in_cnt + 3'(cur[k +: 5] == pat);
      x_cnt  = x_cnt + 3'(!first && (w[k + 4 +: 5] == pat));
    end
  end
  assign any_hit = in_cnt != 3'd0;
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: data-memory sequencer that loads a pattern, scans the message and writes back three hit counts
//   clk, reset (async, active-low), start/done/busy handshake
//   mem_req/mem_gnt/mem_addr/mem_rd_data/mem_wr_en/mem_wr_data: shared data-memory port, a beat completes on req&gnt
//   optional PATTERN_SCAN_PERF_EN adds perf_cycles: busy-cycle count of the last run, saturating
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int         MSG_BYTES = MSG_BYTES_DEF,
  parameter logic [7:0] MSG_BASE  = MSG_BASE_DEF,
  parameter logic [7:0] PAT_ADDR  = PAT_ADDR_DEF,
  parameter logic [7:0] RES_ADDR  = RES_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data
`ifdef PATTERN_SCAN_PERF_EN
  ,
  output logic [15:0] perf_cycles
`endif
);
  state_e     state_q;
  logic       done_q, busy_q, req_q, wr_en_q;
  logic [7:0] addr_q, wr_data_q, idx_q, prev_q, ctb_q, cto_q, cts_q;
  logic [4:0] pat_q;
  logic [2:0] in_cnt, x_cnt;
  logic       any_hit;
  logic [7:0] ctb_d, cts_d;
  logic       start_ok;
  pattern_window_match u_match (
    .pat    (pat_q),
    .cur    (mem_rd_data),
    .prev   (prev_q),
    .first  (idx_q == 8'd0),
    .in_cnt (in_cnt),
    .any_hit(any_hit),
    .x_cnt  (x_cnt)
  );
  assign ctb_d    = ctb_q + 8'(in_cnt);
  assign cts_d    = cts_q + 8'(in_cnt) + 8'(x_cnt);
  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  // done is raised one cycle after entering DONE, so the final write beat is fully retired before completion is visible
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      idx_q     <= '0;
      prev_q    <= '0;
      pat_q     <= '0;
      ctb_q     <= '0;
      cto_q     <= '0;
      cts_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= LDPAT;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            addr_q  <= PAT_ADDR;
          end else if (state_q == DONE) begin
            done_q <= 1'b1;
          end
        end
        LDPAT: if (mem_gnt) begin
          pat_q   <= mem_rd_data[7:3];
          ctb_q   <= '0;
          cto_q   <= '0;
          cts_q   <= '0;
          idx_q   <= '0;
          prev_q  <= '0;
          state_q <= SCAN;
          addr_q  <= MSG_BASE;
        end
        SCAN: if (mem_gnt) begin
          ctb_q  <= ctb_d;
          cto_q  <= cto_q + 8'(any_hit);
          cts_q  <= cts_d;
          prev_q <= mem_rd_data;
          idx_q  <= idx_q + 8'd1;
          if (idx_q == 8'(MSG_BYTES - 1)) begin
            state_q   <= WR0;
            addr_q    <= RES_ADDR + OFF_CTB;
            wr_en_q   <= 1'b1;
            wr_data_q <= ctb_d;
          end else begin
            addr_q <= MSG_BASE + idx_q + 8'd1;
          end
        end
        WR0: if (mem_gnt) begin
          state_q   <= WR1;
          addr_q    <= RES_ADDR + OFF_CTO;
          wr_data_q <= cto_q;
        end
        WR1: if (mem_gnt) begin
          state_q   <= WR2;
          addr_q    <= RES_ADDR + OFF_CTS;
          wr_data_q <= cts_q;
        end
        WR2: if (mem_gnt) begin
          state_q   <= DONE;
          busy_q    <= 1'b0;
          req_q     <= 1'b0;
          wr_en_q   <= 1'b0;
          addr_q    <= '0;
          wr_data_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign done        = done_q;
  assign busy        = busy_q;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
`ifdef PATTERN_SCAN_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else if (start_ok) perf_q <= '0;
    else if (busy_q && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end
  assign perf_cycles = perf_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed self-checking bench for pattern_scan_ctrl with a behavioural memory and count model
module tb_pattern_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       done, busy, mem_req, mem_wr_en;
  logic       mem_gnt = 1'b1;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
`ifdef PATTERN_SCAN_PERF_EN
  logic [15:0] perf_cycles;
`endif
  logic [7:0] img [256];
  logic [7:0] res [256];
  int         wr_cnt = 0;
  int         stall_cnt = 0;
  bit         rand_gnt = 1'b0;
  int         errors = 0;
  int         checks = 0;
  always #5 clk = ~clk;
  pattern_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data)
`ifdef PATTERN_SCAN_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );
  assign mem_rd_data = img[mem_addr];
  always @(posedge clk) begin
    if (mem_req && mem_gnt && mem_wr_en) begin
      res[mem_addr] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_req && !mem_gnt) stall_cnt <= stall_cnt + 1;
  end
  always @(negedge clk) mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Slides a 5-bit window over the whole 256-bit message string; a window is in-byte when it starts at bit 0..3 of a byte.
  function automatic void model(output int tb, output int to, output int ts);
    logic [255:0] s;
    logic [4:0]   p;
    int           h;
    p = img[32][7:3];
    for (int i = 0; i < 32; i++) s[255 - 8 * i -: 8] = img[i];
    tb = 0;
    to = 0;
    ts = 0;
    for (int b = 0; b < 32; b++) begin
      h = 0;
      for (int q = 0; q < 4; q++) if (s[255 - (8 * b + q) -: 5] == p) h++;
      tb += h;
      if (h > 0) to++;
    end
    for (int pp = 0; pp < 252; pp++) if (s[255 - pp -: 5] == p) ts++;
  endfunction
  task automatic run_scan(input string tag, input int e_tb, input int e_to, input int e_ts, input bit extra);
    int edges, s0, w0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s0 = stall_cnt;
    w0 = wr_cnt;
    edges = 0;
    while (!done && edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      start = (extra && edges == 5);
    end
    start = 1'b0;
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " latency"}, edges, 37 + stall_cnt - s0);
    chk({tag, " writes"}, wr_cnt - w0, 3);
    chk({tag, " ctb"}, int'(res[33]), e_tb);
    chk({tag, " cto"}, int'(res[34]), e_to);
    chk({tag, " cts"}, int'(res[35]), e_ts);
`ifdef PATTERN_SCAN_PERF_EN
    chk({tag, " perf"}, int'(perf_cycles), 36 + stall_cnt - s0);
`endif
  endtask
  initial begin
    int m_tb, m_to, m_ts, n, w0;
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    #1;
    chk("rst done", int'(done), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst req", int'(mem_req), 0);
    chk("rst wr_en", int'(mem_wr_en), 0);
    chk("rst addr", int'(mem_addr), 0);
    chk("rst wdata", int'(mem_wr_data), 0);
    @(negedge clk);
    reset = 1'b1;
    run_scan("zeros", 128, 32, 252, 1'b0);
    for (int i = 0; i < 32; i++) img[i] = 8'hFF;
    img[32] = 8'h00;
    run_scan("ones", 0, 0, 0, 1'b0);
    for (int i = 0; i < 32; i++) img[i] = 8'hF0;
    img[32] = 8'h80;
    run_scan("f0", 32, 32, 32, 1'b0);
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    for (int i = 0; i < 6; i++) img[i] = (i % 2 == 0) ? 8'h01 : 8'h80;
    img[32] = 8'hC0;
    model(m_tb, m_to, m_ts);
    chk("cross model", m_ts, 3);
    run_scan("cross", 0, 0, 3, 1'b0);
    for (int i = 0; i < 33; i++) img[i] = 8'($urandom);
    model(m_tb, m_to, m_ts);
    rand_gnt = 1'b1;
    run_scan("rand", m_tb, m_to, m_ts, 1'b0);
    rand_gnt = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(busy && mem_addr == 8'd10) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach idx10", int'(n < 100), 1);
    w0 = wr_cnt;
    reset = 1'b0;
    #1;
    chk("abort done", int'(done), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort req", int'(mem_req), 0);
    chk("abort wr_en", int'(mem_wr_en), 0);
    chk("abort addr", int'(mem_addr), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort writes", wr_cnt - w0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 33; i++) img[i] = 8'($urandom);
    model(m_tb, m_to, m_ts);
    rand_gnt = 1'b1;
    run_scan("restart", m_tb, m_to, m_ts, 1'b1);
    rand_gnt = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Hardware sequencer for the program-3 pattern-count job. It reads a 5-bit pattern and a 32-byte message from data memory. It computes three counts and writes them back to data memory: in-byte matches, bytes with at least one match, and matches that may cross byte boundaries. It sits beside the core as a second requester on the data-memory port, gated by a grant, and reports completion on a start/done handshake.

Parameters:
MSG_BYTES, 32, number of message bytes scanned (byte 0 = most significant of the bit string).
MSG_BASE, 8'd0, address of message byte 0.
PAT_ADDR, 8'd32, address holding the pattern in bits [7:3].
RES_ADDR, 8'd33, results are written to RES_ADDR (in-byte), RES_ADDR+1 (bytes-with-match), RES_ADDR+2 (crossing).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to begin a scan; sampled only in IDLE or DONE.
done  output  1  high while in DONE; cleared by an accepted start or by reset.
busy  output  1  high in LDPAT/SCAN/WR0-WR2.
mem_req  output  1  memory access requested this cycle.
mem_gnt  input  1  access completes only in a cycle with mem_req=1 and mem_gnt=1.
mem_addr  output  8  read/write address.
mem_rd_data  input  8  combinational read data for mem_addr.
mem_wr_en  output  1  write strobe; effective only when mem_gnt=1.
mem_wr_data  output  8  write data.

Behaviour:
- Reset (reset=0, async): state=IDLE. done, busy, mem_req and mem_wr_en = 0. mem_addr and mem_wr_data = 0. All counters, the pattern register and the previous-byte register clear. A reset mid-run aborts the run with no further writes. Results already written stay in memory.
- States: IDLE -> (start) LDPAT -> SCAN -> WR0 -> WR1 -> WR2 -> DONE -> (start) LDPAT.
- Every non-IDLE/DONE state asserts mem_req. The state advances only on a granted cycle. With mem_gnt=0, state, address, counters and outputs hold unchanged.
- LDPAT: mem_addr=PAT_ADDR. On grant, pat <= mem_rd_data[7:3]. All counts and the byte index clear.
- SCAN: mem_addr=MSG_BASE+idx. On grant, for cur=mem_rd_data:
  - ctb += number of k in 0..3 with cur[k+4:k]==pat.
  - cto += 1 if that number is >0.
  - cts += (in-byte count) + (number of k in 0..3 with w[k+8:k+4]==pat, where w={prev[3:0],cur}). The crossing term is skipped when idx==0.
  - prev <= cur. idx increments. Move to WR0 after idx==MSG_BYTES-1.
- Totals: 4 + 8*(MSG_BYTES-1) windows, i.e. 252 for 32 bytes. Maxima are ctb=128, cto=32, cts=252, all 8-bit. No saturation is needed at the default size.
- WR0/WR1/WR2: mem_wr_en=1 and mem_addr=RES_ADDR+0/1/2 with data ctb/cto/cts respectively. Exactly one granted write per result.
- Latency with mem_gnt tied high: done rises 37 edges after the edge that sampled start (1 LDPAT + 32 SCAN + 3 WR + entry to DONE).
- start while busy is ignored. start in DONE drops done on the next edge and restarts at LDPAT.

Optional Feature:
PATTERN_SCAN_PERF_EN:
- Defined: adds output port perf_cycles [15:0]. It clears on an accepted start and increments every cycle while busy, including stalled cycles. It holds in DONE and saturates at 16'hFFFF.
- Undefined: the port and counter do not exist, and all other behaviour is identical.

Decomposition:
- Package pattern_scan_pkg: state enum (IDLE, LDPAT, SCAN, WR0, WR1, WR2, DONE), default address constants, and the result-offset constants 0/1/2.
- One sub-module, pattern_window_match: combinational. Takes pat, cur, prev and first. Returns in-byte count [2:0], any-hit, and crossing count [2:0].

Test Plan:
1. All 32 bytes 0x00, core[32]=0x00, gnt=1 -> writes 128, 32, 252 to 33/34/35; done high 37 edges after start.
2. All bytes 0xFF, pattern 5'b00000 -> writes 0, 0, 0.
3. All bytes 0xF0, pattern 5'b10000 (core[32]=0x80) -> writes 32, 32, 32.
4. Byte pattern alternating 0x01, 0x80, rest of message 0x00, pattern 5'b11000 -> only crossing windows hit; ctb=0, cto=0, cts equal to the number of 0x01->0x80 boundaries; compare against the behavioural model.
5. Random bytes and pattern, mem_gnt random 50% -> results equal the model; exactly 3 granted writes; done delayed by the stall count.
6. reset pulled low at SCAN idx=10 -> outputs zero immediately and no write occurs. Then start -> correct results. A second start while busy has no effect.
